// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit's serial datapaths.
// Holds the control-state encoding and the default operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SUB_WIDTH = 4;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell built from gates: d = a - b - bin.
// Produces the difference bit and the borrow out to the next bit position.
module full_sub (
    output logic d,
    output logic bout,
    input  logic bin,
    input  logic a,
    input  logic b
);

    logic a_x_b;
    logic a_x_b_n;
    logic a_n;
    logic brw_ab;
    logic brw_in;

    xor u_x0 (a_x_b, a, b);
    xor u_x1 (d, a_x_b, bin);
    not u_n0 (a_n, a);
    and u_a0 (brw_ab, a_n, b);
    // Equal bits only pass the incoming borrow through.
    not u_n1 (a_x_b_n, a_x_b);
    and u_a1 (brw_in, a_x_b_n, bin);
    or  u_o0 (bout, brw_ab, brw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// through a single full_sub cell, with a start/busy/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             brw_q;
    logic             d_bit;
    logic             bout_bit;
    logic             accept;

    full_sub u_cell (
        .d    (d_bit),
        .bout (bout_bit),
        .bin  (brw_q),
        .a    (a_sh[0]),
        .b    (b_sh[0])
    );

    assign accept   = start && (state_q != SHIFT);
    // The newest bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign res_next = {d_bit, res_sh};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset as well; diff/borrow must read 0 out of reset.
        if (!rst_n) begin
            cnt_q  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw_q  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            brw_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            brw_q  <= bout_bit;
            res_sh <= res_next[WIDTH-1:1];
            cnt_q  <= cnt_q + CNT_W'(1);
            // Outputs change only on the final bit so they never show partial results.
            if (cnt_q == LAST) begin
                diff   <= res_next;
                borrow <= bout_bit;
            end
        end
    end

endmodule
